// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding, lane helpers
// and write-back payload widths.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LANES     = DATA_W / BYTE_W;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned WB_DATA_W = DATA_W;

    localparam logic [LANES-1:0] BE_WORD = LANES'(4'b1111);

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

    // Request fields held for the duration of an outstanding access
    typedef struct packed {
        logic              we;
        logic              word_byte;
        logic              reg_write;
        logic              reg_src;
        logic [DATA_W-1:0] alu_out;
    } mem_req_t;

    function automatic logic [LANES-1:0] byte_be(input logic [LANE_W-1:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte lane and sign-extends it,
// or passes the full word / ALU result through.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [DATA_W-1:0]    rdata,
    input  logic [LANE_W-1:0]    lane,
    input  logic                 word_byte,
    input  logic                 reg_src,
    input  logic [DATA_W-1:0]    alu_out,
    output logic [WB_DATA_W-1:0] wb_data
);

    logic [BYTE_W-1:0] byte_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: BYTE_W];
        if (!reg_src) begin
            wb_data = alu_out;
        end else if (word_byte) begin
            wb_data = rdata;
        end else begin
            wb_data = {{(WB_DATA_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues word/byte loads and stores through a ready
// handshake, stalls upstream while busy and drives the registered MEM/WB payload.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_alu_out,
    input  logic [DATA_W-1:0]    in_store_data,
    input  logic                 in_mem_data,
    input  logic                 in_mem_write_read,
    input  logic                 in_word_byte,
    input  logic                 in_reg_write,
    input  logic                 in_reg_src,
    input  logic [REG_AW-1:0]    in_dest,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    output logic [LANES-1:0]     dmem_be,
    input  logic                 dmem_ready,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_AW-1:0]    wb_dest,
    output logic [WB_DATA_W-1:0] wb_data,
    output logic                 err_misalign,
    output logic                 err_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_t                 state, state_d;
    logic [CNT_W-1:0]           cnt, cnt_d;
    mem_req_t                   req, req_d;
    logic [REG_AW-1:0]          dest_q, dest_d;
    logic                       dmem_req_d, dmem_we_d;
    logic [DATA_W-1:0]          dmem_addr_d, dmem_wdata_d;
    logic [LANES-1:0]           dmem_be_d;
    logic                       wb_valid_d, wb_reg_write_d;
    logic [REG_AW-1:0]          wb_dest_d;
    logic [WB_DATA_W-1:0]       wb_data_d, load_data;
    logic                       err_misalign_d, err_timeout_d;
    logic                       misaligned;

    assign stall      = (state == MEM_ACCESS);
    assign misaligned = in_word_byte && (in_alu_out[LANE_W-1:0] != '0);

    mem_load_align u_align (
        .rdata     (dmem_rdata),
        .lane      (req.alu_out[LANE_W-1:0]),
        .word_byte (req.word_byte),
        .reg_src   (req.reg_src),
        .alu_out   (req.alu_out),
        .wb_data   (load_data)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        req_d          = req;
        dest_d         = dest_q;
        dmem_req_d     = dmem_req;
        dmem_we_d      = dmem_we;
        dmem_addr_d    = dmem_addr;
        dmem_wdata_d   = dmem_wdata;
        dmem_be_d      = dmem_be;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write;
        wb_dest_d      = wb_dest;
        wb_data_d      = wb_data;
        err_misalign_d = 1'b0;
        err_timeout_d  = 1'b0;

        case (state)
            MEM_IDLE: begin
                if (in_valid && !in_mem_data) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = in_reg_write;
                    wb_dest_d      = in_dest;
                    wb_data_d      = in_alu_out;
                end else if (in_valid && misaligned) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_dest_d      = in_dest;
                    err_misalign_d = 1'b1;
                end else if (in_valid) begin
                    state_d      = MEM_ACCESS;
                    cnt_d        = '0;
                    req_d        = '{we:        in_mem_write_read,
                                     word_byte: in_word_byte,
                                     reg_write: in_reg_write,
                                     reg_src:   in_reg_src,
                                     alu_out:   in_alu_out};
                    dest_d       = in_dest;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = in_mem_write_read;
                    dmem_addr_d  = {in_alu_out[DATA_W-1:LANE_W], LANE_W'(0)};
                    dmem_be_d    = in_word_byte ? BE_WORD : byte_be(in_alu_out[LANE_W-1:0]);
                    dmem_wdata_d = in_word_byte ? in_store_data
                                                : {LANES{in_store_data[BYTE_W-1:0]}};
                end
            end
            MEM_ACCESS: begin
                if (dmem_ready) begin
                    state_d        = MEM_IDLE;
                    cnt_d          = '0;
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    dmem_be_d      = '0;
                    wb_valid_d     = 1'b1;
                    wb_dest_d      = dest_q;
                    wb_reg_write_d = req.reg_write & ~req.we;
                    wb_data_d      = req.we ? '0 : load_data;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d        = MEM_IDLE;
                    cnt_d          = '0;
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    dmem_be_d      = '0;
                    wb_valid_d     = 1'b1;
                    wb_dest_d      = dest_q;
                    wb_reg_write_d = 1'b0;
                    err_timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= MEM_IDLE;
            cnt          <= '0;
            req          <= '0;
            dest_q       <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            req          <= req_d;
            dest_q       <= dest_d;
            dmem_req     <= dmem_req_d;
            dmem_we      <= dmem_we_d;
            dmem_addr    <= dmem_addr_d;
            dmem_wdata   <= dmem_wdata_d;
            dmem_be      <= dmem_be_d;
            wb_valid     <= wb_valid_d;
            wb_reg_write <= wb_reg_write_d;
            wb_dest      <= wb_dest_d;
            wb_data      <= wb_data_d;
            err_misalign <= err_misalign_d;
            err_timeout  <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset corner case and
// randomized operations checked against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mem_data, in_mem_write_read, in_word_byte;
    logic        in_reg_write, in_reg_src;
    logic [31:0] in_alu_out, in_store_data;
    logic [4:0]  in_dest;
    logic        stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, err_misalign, err_timeout;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .REG_AW(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_alu_out        (in_alu_out),
        .in_store_data     (in_store_data),
        .in_mem_data       (in_mem_data),
        .in_mem_write_read (in_mem_write_read),
        .in_word_byte      (in_word_byte),
        .in_reg_write      (in_reg_write),
        .in_reg_src        (in_reg_src),
        .in_dest           (in_dest),
        .stall             (stall),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_ready        (dmem_ready),
        .dmem_rdata        (dmem_rdata),
        .wb_valid          (wb_valid),
        .wb_reg_write      (wb_reg_write),
        .wb_dest           (wb_dest),
        .wb_data           (wb_data),
        .err_misalign      (err_misalign),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        mem, we, word, rw, src;
        logic [4:0]  dest;
        logic [31:0] alu, store, rdata;
        int unsigned wt;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_data;
        logic        e_rw, e_mis, e_to;
        int unsigned e_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic mem, we, word, rw, src, input logic [4:0] dest,
                                input logic [31:0] alu, store, rdata, input int unsigned wt,
                                input logic [3:0] e_be, input logic [31:0] e_wdata, e_data,
                                input logic e_rw, e_mis, e_to, input int unsigned e_stall);
        vec_t v;
        v.mem = mem; v.we = we; v.word = word; v.rw = rw; v.src = src; v.dest = dest;
        v.alu = alu; v.store = store; v.rdata = rdata; v.wt = wt;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_data = e_data;
        v.e_rw = e_rw; v.e_mis = e_mis; v.e_to = e_to; v.e_stall = e_stall;
        return v;
    endfunction

    // Reference model: expected outcome of one transaction from its fields
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int unsigned lane = v.alu % 4;
        int unsigned byte_v = (v.rdata >> (8 * lane)) % 256;
        r.e_mis   = v.mem && v.word && (lane != 0);
        r.e_to    = v.mem && !r.e_mis && (v.wt >= TIMEOUT);
        r.e_be    = v.word ? 4'hF : 4'(1 << lane);
        r.e_wdata = v.word ? v.store : (v.store % 256) * 32'h0101_0101;
        if (!v.mem || (!v.we && !v.src)) r.e_data = v.alu;
        else if (v.we)                   r.e_data = 32'h0;
        else if (v.word)                 r.e_data = v.rdata;
        else if (byte_v < 128)           r.e_data = byte_v;
        else                             r.e_data = byte_v + 32'hFFFF_FF00;
        r.e_rw    = v.mem ? (v.rw && !v.we && !r.e_mis && !r.e_to) : v.rw;
        r.e_stall = (!v.mem || r.e_mis) ? 0 : (r.e_to ? TIMEOUT : v.wt + 1);
        return r;
    endfunction

    // Issue one instruction from IDLE, serve its memory access, check the retirement
    task automatic run_op(input vec_t v, input string tag);
        int unsigned stalls = 0;
        int unsigned k = 0;
        in_valid = 1'b1; in_mem_data = v.mem; in_mem_write_read = v.we;
        in_word_byte = v.word; in_reg_write = v.rw; in_reg_src = v.src;
        in_dest = v.dest; in_alu_out = v.alu; in_store_data = v.store;
        dmem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        if (v.e_stall != 0) begin
            chk({tag, ".req"},   32'(dmem_req), 32'(1));
            chk({tag, ".we"},    32'(dmem_we), 32'(v.we));
            chk({tag, ".be"},    32'(dmem_be), 32'(v.e_be));
            chk({tag, ".addr"},  dmem_addr, v.alu & 32'hFFFF_FFFC);
            chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
            chk({tag, ".nowb"},  32'(wb_valid), 32'(0));
        end else begin
            chk({tag, ".noreq"}, 32'(dmem_req), 32'(0));
        end
        while (stall && k < 40) begin
            stalls++;
            dmem_ready = (k == v.wt);
            dmem_rdata = dmem_ready ? v.rdata : $urandom;
            tick();
            k++;
        end
        dmem_ready = 1'b0;
        chk({tag, ".stalls"},  stalls, v.e_stall);
        chk({tag, ".wbv"},     32'(wb_valid), 32'(1));
        chk({tag, ".rw"},      32'(wb_reg_write), 32'(v.e_rw));
        chk({tag, ".mis"},     32'(err_misalign), 32'(v.e_mis));
        chk({tag, ".to"},      32'(err_timeout), 32'(v.e_to));
        chk({tag, ".reqdone"}, 32'(dmem_req), 32'(0));
        if (!v.e_mis && !v.e_to) begin
            chk({tag, ".dest"}, 32'(wb_dest), 32'(v.dest));
            chk({tag, ".data"}, wb_data, v.e_data);
        end
        tick();
        chk({tag, ".pulse"}, {29'b0, wb_valid, err_misalign, err_timeout}, 32'(0));
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mem_data = 1'b0; in_mem_write_read = 1'b0;
        in_word_byte = 1'b0; in_reg_write = 1'b0; in_reg_src = 1'b0; in_dest = '0;
        in_alu_out = '0; in_store_data = '0; dmem_ready = 1'b0; dmem_rdata = '0;

        // mem we wd rw src dest alu store rdata wt | be wdata data rw mis to stall
        tbl.push_back(mk(0,0,1,1,1, 8, 32'd212, 0, 0, 0,                 4'h0, 0, 32'd212, 1,0,0, 0));
        tbl.push_back(mk(1,0,1,1,1, 3, 32'h100, 0, 32'h4808_0000, 3,     4'hF, 0, 32'h4808_0000, 1,0,0, 4));
        tbl.push_back(mk(1,0,0,1,1, 4, 32'h103, 0, 32'h80FF_1234, 0,     4'h8, 0, 32'hFFFF_FF80, 1,0,0, 1));
        tbl.push_back(mk(1,0,0,1,1, 5, 32'h101, 0, 32'h80FF_1234, 2,     4'h2, 0, 32'h0000_0012, 1,0,0, 3));
        tbl.push_back(mk(1,1,0,1,1, 6, 32'h102, 32'hAB, 32'h5555_5555, 0, 4'h4, 32'hABAB_ABAB, 0, 0,0,0, 1));
        tbl.push_back(mk(1,1,1,1,1, 7, 32'h200, 32'hDEAD_BEEF, 0, 1,     4'hF, 32'hDEAD_BEEF, 0, 0,0,0, 2));
        tbl.push_back(mk(1,0,1,1,0, 9, 32'h40, 0, 32'h1111_1111, 0,      4'hF, 0, 32'h40, 1,0,0, 1));
        tbl.push_back(mk(1,0,1,1,1, 10, 32'h102, 0, 0, 0,                4'h0, 0, 0, 0,1,0, 0));
        tbl.push_back(mk(1,0,0,1,1, 11, 32'h100, 32'h1C3, 32'h1234_567F, 0, 4'h1, 32'hC3C3_C3C3, 32'h7F, 1,0,0, 1));
        tbl.push_back(mk(1,0,1,1,1, 12, 32'h44, 0, 32'hCAFE_F00D, 15,    4'hF, 0, 32'hCAFE_F00D, 1,0,0, 16));
        tbl.push_back(mk(1,0,1,1,1, 13, 32'h300, 0, 0, 99,               4'hF, 0, 0, 0,0,1, 16));
        tbl.push_back(mk(0,0,1,0,1, 14, 32'hFFFF_FFFF, 0, 0, 0,          4'h0, 0, 32'hFFFF_FFFF, 0,0,0, 0));

        tick(); tick(); tick();
        chk("reset.ctl", {26'b0, stall, dmem_req, dmem_we, wb_valid, err_misalign, err_timeout}, 32'(0));
        chk("reset.be",   32'(dmem_be), 32'(0));
        chk("reset.addr", dmem_addr, 32'h0);
        chk("reset.wb",   {26'b0, wb_reg_write, wb_dest}, 32'(0));
        chk("reset.data", wb_data, 32'h0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted in the middle of an outstanding access
        in_valid = 1'b1; in_mem_data = 1'b1; in_mem_write_read = 1'b0; in_word_byte = 1'b1;
        in_reg_write = 1'b1; in_reg_src = 1'b1; in_dest = 5'd21; in_alu_out = 32'h500;
        tick();
        in_valid = 1'b0;
        chk("rstmid.stall", 32'(stall), 32'(1));
        tick(); tick();
        rst_n = 1'b0;
        dmem_ready = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ready = 1'b0;
        chk("rstmid.ctl", {28'b0, stall, dmem_req, wb_valid, err_timeout}, 32'(0));
        chk("rstmid.wb",  {26'b0, wb_reg_write, wb_dest}, 32'(0));
        chk("rstmid.data", wb_data, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rstmid.idle", {30'b0, stall, wb_valid}, 32'(0));
        run_op(tbl[0], "postrst");

        // Randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            v.mem   = ($urandom_range(0, 3) != 0);
            v.we    = 1'($urandom_range(0, 1));
            v.word  = 1'($urandom_range(0, 1));
            v.rw    = 1'($urandom_range(0, 1));
            v.src   = ($urandom_range(0, 4) != 0);
            v.dest  = 5'($urandom);
            v.alu   = $urandom;
            if ($urandom_range(0, 3) != 0) v.alu = v.alu & 32'hFFFF_FFFC;
            if (v.alu[0]) v.alu[1:0] = 2'($urandom);
            v.store = $urandom;
            v.rdata = $urandom;
            v.wt    = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
            run_op(model(v), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs: ALU result, store data (data_read3), control bits and destination register.
- Performs word/byte loads and stores against the data memory through a ready-handshake. Stalls upstream while an access is outstanding.
- Drives the registered MEM/WB payload for the write-back stage.

Parameters:
- TIMEOUT, 16: maximum wait cycles for dmem_ready before the access is aborted.
- REG_AW, 5: register-file index width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_alu_out  in  32  ALU result; used as the memory address for memory ops
- in_store_data  in  32  store data (data_read3)
- in_mem_data  in  1  1 = instruction accesses memory
- in_mem_write_read  in  1  1 = store, 0 = load
- in_word_byte  in  1  1 = word, 0 = byte
- in_reg_write  in  1  instruction writes the register file
- in_reg_src  in  1  1 = WB data from memory, 0 = from ALU
- in_dest  in  REG_AW  write-back register index
- stall  out  1  upstream must hold EX/MEM contents
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  write data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_reg_write  out  1  registered write enable
- wb_dest  out  REG_AW  registered destination
- wb_data  out  32  registered write-back data
- err_misalign  out  1  one-cycle pulse: misaligned word access
- err_timeout  out  1  one-cycle pulse: memory timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. rst_n low mid-access aborts the access immediately; dmem_req drops on the next edge and no wb_valid is produced.
- Two FSM states, IDLE and ACCESS. stall = (state==ACCESS), combinational.
- IDLE, in_valid=1, in_mem_data=0:
  - at the next edge: wb_valid=1, wb_reg_write=in_reg_write, wb_dest=in_dest, wb_data=in_alu_out. Latency 1.
- IDLE, in_valid=1, in_mem_data=1, aligned (byte access, or word access with addr[1:0]==0):
  - capture the request and go to ACCESS.
  - wb_valid stays 0 that edge.
- IDLE, word access with addr[1:0]!=0:
  - no memory request.
  - next edge: wb_valid=1, wb_reg_write=0, err_misalign=1.
- ACCESS, request signals:
  - dmem_req=1; dmem_we=captured mem_write_read.
  - Word access: dmem_be=4'b1111, dmem_wdata=store_data.
  - Byte access: dmem_be=1<<addr[1:0], dmem_wdata=store_data[7:0] replicated into all 4 lanes.
  - Lanes are little-endian.
- ACCESS, dmem_ready=1, edge actions:
  - return to IDLE with wb_valid=1 and wb_dest=captured dest.
  - wb_reg_write = captured reg_write & ~mem_write_read.
  - Load word: wb_data=dmem_rdata.
  - Load byte: wb_data = dmem_rdata byte at lane addr[1:0], sign-extended.
  - Store: wb_data=0.
  - reg_src=0 on a load: wb_data=captured alu_out.
- Back-to-back issue: no new instruction is accepted on the completion edge. The next instruction is accepted in the following IDLE cycle, so a memory op occupies 2 + wait cycles.
- Timeout counter:
  - increments each ACCESS cycle with dmem_ready=0.
  - when it reaches TIMEOUT-1 with dmem_ready still 0, next edge: IDLE, dmem_req=0, wb_valid=1, wb_reg_write=0, err_timeout=1, counter cleared.
  - if dmem_ready=1 on that same cycle, completion wins and no error is raised.
- wb_* hold their values between pulses; only wb_valid and the err_* signals are pulses.

Decomposition:
- Shared pipeline package holds:
  - the MEM state encoding (IDLE=1'b0, ACCESS=1'b1)
  - lane/byte-enable helper constants
  - the write-back payload width constants
- One sub-module, mem_load_align: combinational lane select plus sign extension (inputs rdata, addr[1:0], word_byte, reg_src, alu_out; output wb_data). Everything else is inline.

Test Plan:
- ALU op: in_alu_out=212, in_dest=8, reg_write=1, mem_data=0 -> next cycle wb_valid=1, wb_data=212, wb_dest=8, stall never asserted.
- Load word at 0x100, dmem_ready after 3 wait cycles, rdata=0x48080000 -> stall high 4 cycles, dmem_be=4'hF, then wb_data=0x48080000, wb_reg_write=1.
- Load byte at 0x103, rdata=0x80FF_1234 -> dmem_be=4'b1000, wb_data=0xFFFF_FF80. Repeat at 0x101 -> wb_data=0x0000_0012.
- Store byte at 0x102, store_data=0xAB -> dmem_we=1, dmem_be=4'b0100, dmem_wdata=0xABABABAB, wb_reg_write=0.
- Word load at 0x102 -> no dmem_req, err_misalign pulse, wb_reg_write=0. Separately, dmem_ready held 0 -> err_timeout after 16 ACCESS cycles, stall released.
- rst_n=0 during ACCESS -> next edge: dmem_req=0, stall=0, all wb_* 0, no wb_valid pulse.
